sys_ctrl_rx_cmd: RTL
====================

# sys_ctrl_rx_cmd

Receive-side command sequencer of the system controller. It parses byte frames arriving from the UART RX deserializer and drives the register file and ALU: register write, register read, ALU op with operands, and ALU op without operands. It gates the ALU clock around each operation. Read data and ALU results return to the host through the existing TX-side controller, not through this block.

## Interface
Parameters:
- DATA_WIDTH, 8, width of RX bytes and register-file write data
- ADDR_WIDTH, 4, register-file address width; taken from the low bits of the address byte
- FUN_WIDTH, 4, ALU function code width; taken from the low bits of the FUN byte
- TIMEOUT_CYCLES, 1024, inter-byte timeout; used only when SYS_CTRL_RX_TIMEOUT_EN is defined

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe marking a valid RX_P_DATA byte; may arrive back-to-back
- ALU_OUT_valid  in  1  ALU result valid
- Address  out  ADDR_WIDTH  register-file address
- WrEn  out  1  register-file write strobe, one cycle
- RdEn  out  1  register-file read strobe, one cycle
- WrData  out  DATA_WIDTH  register-file write data
- ALU_FUN  out  FUN_WIDTH  ALU function code
- ALU_EN  out  1  ALU start strobe, one cycle
- CLK_GATE_EN  out  1  ALU clock-gate enable
- Frame_err  out  1  one-cycle error pulse
- Busy  out  1  high whenever the state is not IDLE

## Operation
- Opcodes:
  - 0xAA: write, frame [addr, data]
  - 0xBB: read, frame [addr]
  - 0xCC: ALU with operands, frame [A, B, FUN]
  - 0xDD: ALU without operands, frame [FUN]
- The FSM consumes one byte per RX_D_VLD cycle. Cycles without RX_D_VLD hold the current state.
- States and transitions:
  - IDLE: opcode decode. AA goes to WR_ADDR, BB to RD_ADDR, CC to ALU_A, DD to ALU_FUN. Any other byte stays in IDLE and pulses Frame_err.
  - WR_ADDR: latch the address, go to WR_DATA.
  - WR_DATA: pulse WrEn with the latched Address and WrData = byte, go to IDLE.
  - RD_ADDR: pulse RdEn with Address = byte, go to IDLE.
  - ALU_A: write the byte to address 0x0 (WrEn pulse), go to ALU_B.
  - ALU_B: write the byte to address 0x1 (WrEn pulse), go to ALU_FUN.
  - ALU_FUN: pulse ALU_EN with ALU_FUN = byte, set CLK_GATE_EN, go to ALU_WAIT.
  - ALU_WAIT: on ALU_OUT_valid, clear CLK_GATE_EN and go to IDLE.
- In ALU_WAIT, any RX_D_VLD byte is dropped and pulses Frame_err.
- If RX_D_VLD and ALU_OUT_valid are high in the same cycle in ALU_WAIT, the completion is taken, the byte is dropped, and Frame_err pulses.
- Address and data bytes are never checked against opcode values; 0xAA in a data position is data.
- Address bits above ADDR_WIDTH-1 and FUN bits above FUN_WIDTH-1 are discarded.

## Timing
- All outputs are registered. A strobe caused by the byte sampled at edge t is visible after edge t, for exactly one cycle.
- Address, WrData and ALU_FUN hold their last value until the next update.
- Frame latency from the first byte's strobe to the action strobe is N cycles for an N-byte frame, when bytes arrive back-to-back.
- CLK_GATE_EN rises together with ALU_EN. It falls the cycle after ALU_OUT_valid is sampled high, so the minimum width is 1 cycle.
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-frame discards the partial frame and drops CLK_GATE_EN immediately (asynchronous).

## Configuration
- SYS_CTRL_RX_TIMEOUT_EN defined:
  - A counter runs in any state other than IDLE and ALU_WAIT, and clears on each RX_D_VLD.
  - When it reaches TIMEOUT_CYCLES with no byte, the FSM returns to IDLE and Frame_err pulses once.
  - ALU_WAIT is not timed out.
- Undefined: no counter; a partial frame waits indefinitely.

## Structure
- Shared package sys_ctrl_pkg:
  - opcode constants: CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP
  - operand addresses: OPA_ADDR = 0x0, OPB_ADDR = 0x1
  - the state enum
- One sub-module: sys_ctrl_rx_timeout, the inter-byte counter, instantiated only under SYS_CTRL_RX_TIMEOUT_EN.

## Test plan
- Write: bytes AA,05,3C back-to-back produce one WrEn pulse with Address=5, WrData=0x3C, aligned one cycle after the 3C strobe; Busy is low afterwards.
- Read: bytes BB,0A produce one RdEn pulse with Address=0xA; WrEn stays 0.
- ALU with operands: bytes CC,12,34,02 with ALU_OUT_valid raised 3 cycles after ALU_EN produce:
  - WrEn at address 0 with 0x12
  - WrEn at address 1 with 0x34
  - ALU_EN with ALU_FUN=2
  - CLK_GATE_EN high for 4 cycles
- Errors: an unknown byte 0x55 in IDLE pulses Frame_err with no other strobe. A byte sent during ALU_WAIT is dropped and pulses Frame_err, and the ALU op still completes.
- Reset: rst asserted after AA,05 and then released, followed by 3C, produces no WrEn; 3C is treated as an unknown opcode and pulses Frame_err.
- Timeout (macro on, TIMEOUT_CYCLES=16): AA followed by 16 idle cycles pulses Frame_err and returns to IDLE; a following BB,01 produces RdEn at address 1.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared opcodes, operand addresses and RX command FSM states
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT
  } rx_state_t;
endpackage

// File: rtl/sys_ctrl_rx_timeout.sv
// sys_ctrl_rx_timeout: inter-byte idle counter that flags an abandoned partial frame
module sys_ctrl_rx_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic rst,
  input  logic active,
  input  logic vld,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expire = active && !vld && (cnt == W'(TIMEOUT_CYCLES - 1));
  // count idle cycles while a frame is open; any byte or expiry restarts the count
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= (!active || vld || expire) ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/sys_ctrl_rx_cmd.sv
// sys_ctrl_rx_cmd: RX frame parser driving register file and ALU; inter-byte timeout enabled by SYS_CTRL_RX_TIMEOUT_EN
module sys_ctrl_rx_cmd
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  ALU_OUT_valid,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  Frame_err,
  output logic                  Busy
);
  rx_state_t state;
  logic      timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef SYS_CTRL_RX_TIMEOUT_EN
  logic active;
  assign active = (state != ST_IDLE) && (state != ST_ALU_WAIT);
  sys_ctrl_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK   (CLK),
    .rst   (rst),
    .active(active),
    .vld   (RX_D_VLD),
    .expire(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // one byte per RX_D_VLD; strobes are single-cycle, data outputs hold until rewritten
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      Address     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Frame_err   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      ALU_EN    <= 1'b0;
      Frame_err <= 1'b0;
      if (state == ST_ALU_WAIT) begin
        Frame_err <= RX_D_VLD;
        if (ALU_OUT_valid) begin
          CLK_GATE_EN <= 1'b0;
          state       <= ST_IDLE;
          Busy        <= 1'b0;
        end
      end else if (timeout) begin
        state     <= ST_IDLE;
        Busy      <= 1'b0;
        Frame_err <= 1'b1;
      end else if (RX_D_VLD) begin
        case (state)
          ST_IDLE: begin
            case (RX_P_DATA)
              DATA_WIDTH'(CMD_RF_WR):   begin state <= ST_WR_ADDR; Busy <= 1'b1; end
              DATA_WIDTH'(CMD_RF_RD):   begin state <= ST_RD_ADDR; Busy <= 1'b1; end
              DATA_WIDTH'(CMD_ALU_OP):  begin state <= ST_ALU_A;   Busy <= 1'b1; end
              DATA_WIDTH'(CMD_ALU_NOP): begin state <= ST_ALU_FUN; Busy <= 1'b1; end
              default: Frame_err <= 1'b1;
            endcase
          end
          ST_WR_ADDR: begin
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            WrEn   <= 1'b1;
            WrData <= RX_P_DATA;
            state  <= ST_IDLE;
            Busy   <= 1'b0;
          end
          ST_RD_ADDR: begin
            RdEn    <= 1'b1;
            Address <= RX_P_DATA[ADDR_WIDTH-1:0];
            state   <= ST_IDLE;
            Busy    <= 1'b0;
          end
          ST_ALU_A: begin
            WrEn    <= 1'b1;
            Address <= ADDR_WIDTH'(OPA_ADDR);
            WrData  <= RX_P_DATA;
            state   <= ST_ALU_B;
          end
          ST_ALU_B: begin
            WrEn    <= 1'b1;
            Address <= ADDR_WIDTH'(OPB_ADDR);
            WrData  <= RX_P_DATA;
            state   <= ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            ALU_EN      <= 1'b1;
            ALU_FUN     <= RX_P_DATA[FUN_WIDTH-1:0];
            CLK_GATE_EN <= 1'b1;
            state       <= ST_ALU_WAIT;
          end
          default: begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
